// File: rtl/song_scheduler.sv
// song_scheduler: picks the song (order/random/choice) and steps the shared ROM address on each accepted tick.
// Latency: start -> song_sel 2 cycles; accepted tick -> sample_valid next cycle; last sample -> song_done next cycle.
// Backpressure: none; ticks that arrive outside PLAY are dropped, never queued. pause freezes playback in HOLD.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   tick                  one-cycle sample strobe
//   start/stop/skip       control pulses; pause, repeat_en are levels
//   mode, choice          0/3 = order, 1 = random (no back-to-back repeat), 2 = choice
//   rand_val              free-running random song index
//   song_sel, rom_addr    ROM bank select and shared read address
//   sample_valid          ROM word at rom_addr is a fresh sample
//   song_done             one-cycle pulse at each song end
//   playing               high whenever the sequencer is out of IDLE
module song_scheduler #(
  parameter int ADDR_W = 11,
  parameter int LEN0   = 270,
  parameter int LEN1   = 220,
  parameter int LEN2   = 260,
  parameter int LEN3   = 260
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              repeat_en,
  input  logic              skip,
  input  logic [1:0]        mode,
  input  logic [1:0]        choice,
  input  logic [1:0]        rand_val,
  output logic [1:0]        song_sel,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              sample_valid,
  output logic              song_done,
  output logic              playing
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_PLAY, S_VALID, S_HOLD, S_END
  } state_t;

  localparam logic [ADDR_W-1:0] LAST0 = ADDR_W'(LEN0 - 1);
  localparam logic [ADDR_W-1:0] LAST1 = ADDR_W'(LEN1 - 1);
  localparam logic [ADDR_W-1:0] LAST2 = ADDR_W'(LEN2 - 1);
  localparam logic [ADDR_W-1:0] LAST3 = ADDR_W'(LEN3 - 1);

  state_t              state_q, state_d;
  logic [1:0]          song_sel_q, song_sel_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                first_q, first_d;
  logic                sample_valid_q, sample_valid_d;
  logic                song_done_q, song_done_d;
  logic                playing_q, playing_d;
  logic [ADDR_W-1:0]   last_addr;
  logic [1:0]          pick_sel;

  // Address of the final sample of the song currently selected.
  always_comb begin
    case (song_sel_q)
      2'd0:    last_addr = LAST0;
      2'd1:    last_addr = LAST1;
      2'd2:    last_addr = LAST2;
      default: last_addr = LAST3;
    endcase
  end

  // Song chosen when leaving SELECT. Random mode bumps a repeat of the
  // previous song to the next index so a song never plays twice in a row.
  always_comb begin
    pick_sel = first_q ? 2'd0 : song_sel_q + 2'd1;
    case (mode)
      2'd1:    pick_sel = (!first_q && rand_val == song_sel_q) ? rand_val + 2'd1 : rand_val;
      2'd2:    pick_sel = choice;
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    song_sel_d = song_sel_q;
    rom_addr_d = rom_addr_q;
    first_d    = first_q;
    if (stop) begin
      // song_sel is deliberately held so the ROM mux does not glitch on abort.
      state_d    = S_IDLE;
      rom_addr_d = '0;
      first_d    = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (start) state_d = S_SELECT;
        S_SELECT: begin
          song_sel_d = pick_sel;
          rom_addr_d = '0;
          first_d    = 1'b0;
          state_d    = S_PLAY;
        end
        S_PLAY: begin
          if (pause)                                    state_d = S_HOLD;
          else if (skip)                                state_d = S_END;
          else if (tick)                                state_d = S_VALID;
          else if (mode == 2'd2 && choice != song_sel_q) state_d = S_SELECT;
        end
        S_VALID: begin
          // >= rather than == keeps the address bounded even if it were ever corrupted.
          if (rom_addr_q >= last_addr) begin
            state_d = S_END;
          end else begin
            rom_addr_d = rom_addr_q + ADDR_W'(1);
            state_d    = S_PLAY;
          end
        end
        S_HOLD: if (!pause) state_d = S_PLAY;
        S_END: begin
          if (repeat_en) begin
            rom_addr_d = '0;
            state_d    = S_PLAY;
          end else begin
            state_d = S_SELECT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registered copies of what the next state implies.
  always_comb begin
    sample_valid_d = (state_d == S_VALID);
    song_done_d    = (state_d == S_END);
    playing_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      song_sel_q     <= '0;
      rom_addr_q     <= '0;
      first_q        <= 1'b1;
      sample_valid_q <= 1'b0;
      song_done_q    <= 1'b0;
      playing_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      song_sel_q     <= song_sel_d;
      rom_addr_q     <= rom_addr_d;
      first_q        <= first_d;
      sample_valid_q <= sample_valid_d;
      song_done_q    <= song_done_d;
      playing_q      <= playing_d;
    end
  end

  assign song_sel     = song_sel_q;
  assign rom_addr     = rom_addr_q;
  assign sample_valid = sample_valid_q;
  assign song_done    = song_done_q;
  assign playing      = playing_q;

endmodule
